ps2_rx_mmio: RTL and testbench
==============================

# ps2_rx_mmio

Receives PS/2 keyboard frames on the board's `ps2_clk`/`ps2_data` pins and buffers scan codes in a small FIFO. The processor reads them through the memory-mapped I/O window next to the switch, LED and audio registers. This is the device-to-CPU read path complementing the CPU-to-device write registers. The wrapper ORs `hit` into the `q_dmem` select mux.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: scan-code entries; power of two, 2–16.
- `ADDR_DATA`, 32'd4099: data/pop register address.
- `ADDR_STAT`, 32'd4100: status/clear register address.
- `TIMEOUT_CYCLES`, 50000: idle-clock watchdog per frame, 1 ms at 50 MHz.

Ports:
- `clock`  in  1: 50 MHz system clock, all logic on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: PS/2 clock pad, asynchronous, idle high.
- `ps2_data`  in  1: PS/2 data pad, asynchronous, idle high.
- `mem_addr`  in  32: processor data address.
- `rd_strobe`  in  1: one-cycle pulse per load instruction.
- `wren`  in  1: processor store enable.
- `hit`  out  1: `mem_addr` equals `ADDR_DATA` or `ADDR_STAT`. Combinational.
- `rd_data`  out  32: register read value. Combinational; 0 when `hit`=0.

## Operation
- Both pads pass through 2-flop synchronizers. A falling edge is sync-stage-2 high in the previous cycle and low now. Data is sampled from the synchronized `ps2_data` on that edge.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM states:
  - IDLE → DATA on a falling edge with data=0. A falling edge with data=1 is ignored.
  - DATA shifts 8 bits using a 3-bit counter, then → PARITY.
  - PARITY latches the parity bit, then → STOP.
  - STOP → IDLE on the next falling edge.
- At STOP:
  - If stop=1 and XOR(data, parity)=1, push the code.
  - Otherwise discard the frame and set sticky `parity_err`.
- Push when the FIFO is full: drop the code and set sticky `overflow`.
- DATA register read: `{23'b0, valid, code[7:0]}`.
  - `valid` = not empty; `code` = FIFO head.
  - `rd_strobe`, address `ADDR_DATA`, not empty → pop.
  - Read when empty returns 0 and has no side effect.
- STATUS register read:
  - [4:0] count
  - [5] empty
  - [6] full
  - [8] `parity_err`
  - [9] `overflow`
  - [10] `frame_err`
  - all other bits 0.
- Store (`wren`) to `ADDR_STAT`, any data → clear all sticky flags. Stores to `ADDR_DATA` are ignored.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur, count unchanged.
  - Empty FIFO: pop is a no-op, push proceeds.
  - Full FIFO: pop frees a slot and push is accepted; no overflow.
- Simultaneous flag set (same cycle as clear) → set wins.

## Timing
- Reset values: FSM IDLE, FIFO empty, count 0, all flags 0, sync flops 1, `rd_data`/`hit` combinational (0 when address is idle).
- Pad edge to internal edge detect: 2–3 cycles. Maximum PS/2 clock is 16.7 kHz, so at most one edge per ~3000 cycles.
- Push occurs in the cycle after the stop-bit edge is detected. `valid` and `count` reflect it on the next posedge.
- Pop updates the head on the posedge ending the `rd_strobe` cycle. `rd_data` in the strobe cycle shows the popped entry.
- Reset asserted mid-frame: the partial frame is lost with no flag set. After deassertion, reception restarts at the next start bit.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - While not IDLE, a counter reloads on each falling edge.
  - Reaching `TIMEOUT_CYCLES` without an edge → discard the frame, set `frame_err`, return to IDLE.
- Undefined: no watchdog and `frame_err` reads 0. A stalled frame holds the FSM until the next edges complete it.

## Structure
- Package `ps2_rx_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - default address constants
  - STATUS bit-position constants
  - frame bit count (11)
- Sub-module `ps2_rx_fifo`: synchronous FIFO with push/pop/full/empty/count and head data, parameterized by depth and width 8.

## Test plan
- Frame 0x1C, parity 0, stop 1 → DATA reads 0x11C, then 0x000. STATUS count goes 1 → 0.
- Frame 0xF0 with parity 0 (bad) → FIFO stays empty and STATUS[8]=1. A store to `ADDR_STAT` clears it to 0.
- Nine valid frames 0x01..0x09, no reads → count=8, full=1, overflow=1. Reads return 0x101..0x108, then 0x000.
- Pop strobe in the same cycle as the push of 0x2A, FIFO holding 0x15 → read returns 0x115, count stays 1, next read 0x12A.
- With `PS2_RX_TIMEOUT_EN`: start bit plus 4 data bits, then pads idle → after 50000 cycles STATUS[10]=1 and FSM IDLE. Next frame 0x1C is received correctly.
- `reset_n` low after 6 bits of a frame → all outputs and flags 0. A following full frame 0x5A reads 0x15A.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx_pkg                                                |
// | Purpose  : Shared types and constants for the PS/2 receive MMIO      |
// |            block: receiver FSM states, default register addresses,   |
// |            STATUS register bit positions and PS/2 frame length.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ps2_rx_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Default memory-mapped register addresses
  localparam logic [31:0] DEF_ADDR_DATA = 32'd4099;
  localparam logic [31:0] DEF_ADDR_STAT = 32'd4100;

  // STATUS register layout
  localparam int STAT_COUNT_W   = 5;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_PERR_BIT  = 8;
  localparam int STAT_OVF_BIT   = 9;
  localparam int STAT_FERR_BIT  = 10;

  // Start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx_fifo                                               |
// | Purpose  : Small synchronous FIFO holding received scan codes.       |
// |            A push while full is accepted only when a pop happens in  |
// |            the same cycle (the pop frees the slot).                  |
// | Ports    : clock, reset_n (async, active low)                        |
// |            push/push_data  - write request and data                  |
// |            pop             - read request (ignored when empty)       |
// |            head            - oldest entry (undefined when empty)     |
// |            full/empty/count- occupancy                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle makes room even when full
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx_mmio                                               |
// | Purpose  : PS/2 keyboard receiver with scan-code FIFO, exposed to    |
// |            the processor as two memory-mapped registers:             |
// |              ADDR_DATA - {23'b0, valid, code}, load pops the FIFO    |
// |              ADDR_STAT - count/empty/full/parity_err/overflow/       |
// |                          frame_err, any store clears sticky flags    |
// | Ports    : clock, reset_n (async, active low)                        |
// |            ps2_clk, ps2_data - asynchronous pads, idle high          |
// |            mem_addr, rd_strobe, wren - processor data bus            |
// |            hit, rd_data - combinational register decode / read value |
// | Config   : define PS2_RX_TIMEOUT_EN to enable the per-frame idle     |
// |            clock watchdog that aborts stalled frames (frame_err).    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_rx_mmio
  import ps2_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] ADDR_DATA      = DEF_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT      = DEF_ADDR_STAT,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] mem_addr,
  input  logic        rd_strobe,
  input  logic        wren,
  output logic        hit,
  output logic [31:0] rd_data
);

  localparam int DATA_BITS = FRAME_BITS - 3;

  // ---------------------------------------------------------------- pads
  logic clk_s1, clk_s2, clk_s2_d;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_s2_d <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_s2_d <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_s2_d & ~clk_s2;

  // ----------------------------------------------------------------- FSM
  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       frame_ok;
  logic       frame_bad;
  logic       timeout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE:   if (fall && !dat_s2) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          // Odd parity: data bits plus parity bit must contain an odd count of ones
          if (dat_s2 && (^{shreg, par_bit})) frame_ok  = 1'b1;
          else                               frame_bad = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Watchdog only fires on cycles without an edge, so it never races a frame check
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == DATA) begin
        shreg   <= {dat_s2, shreg[7:1]};   // LSB arrives first
        bit_cnt <= bit_cnt + 3'd1;
      end else if (fall && state == PARITY) begin
        par_bit <= dat_s2;
      end
    end
  end

  // ------------------------------------------------------------ watchdog
  logic frame_err;
  logic clr_flags;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE || fall) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_ONE;
    end
  end

  assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_END);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout | (frame_err & ~clr_flags);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  // ---------------------------------------------------- push stage, FIFO
  logic       push_req;
  logic [7:0] push_code;
  logic       pop_req;
  logic [7:0] head;
  logic       full;
  logic       empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Accepted frames are pushed in the cycle after the stop-bit edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      push_req  <= 1'b0;
      push_code <= '0;
    end else begin
      push_req  <= frame_ok;
      if (frame_ok) push_code <= shreg;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (push_code),
    .pop       (pop_req),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // ------------------------------------------------------- bus interface
  logic hit_data;
  logic hit_stat;
  logic parity_err;
  logic overflow;
  logic [31:0] data_word;
  logic [31:0] stat_word;

  assign hit_data  = (mem_addr == ADDR_DATA);
  assign hit_stat  = (mem_addr == ADDR_STAT);
  assign hit       = hit_data | hit_stat;
  assign pop_req   = rd_strobe & hit_data & ~empty;
  assign clr_flags = wren & hit_stat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Set has priority over a clear in the same cycle
      parity_err <= frame_bad | (parity_err & ~clr_flags);
      overflow   <= (push_req & full & ~pop_req) | (overflow & ~clr_flags);
    end
  end

  always_comb begin
    data_word = '0;
    if (!empty) data_word = {23'b0, 1'b1, head};
  end

  always_comb begin
    stat_word                     = '0;
    stat_word[STAT_COUNT_W-1:0]   = STAT_COUNT_W'(fifo_count);
    stat_word[STAT_EMPTY_BIT]     = empty;
    stat_word[STAT_FULL_BIT]      = full;
    stat_word[STAT_PERR_BIT]      = parity_err;
    stat_word[STAT_OVF_BIT]       = overflow;
    stat_word[STAT_FERR_BIT]      = frame_err;
  end

  always_comb begin
    rd_data = '0;
    if (hit_data)      rd_data = data_word;
    else if (hit_stat) rd_data = stat_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_rx_mmio                                            |
// | Purpose  : Self-checking bench for ps2_rx_mmio. Drives PS/2 frames   |
// |            on the pads and compares register reads against a queue   |
// |            based model of the scan-code buffer and sticky flags.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ps2_rx_mmio;

  localparam logic [31:0] A_DATA = 32'd4099;
  localparam logic [31:0] A_STAT = 32'd4100;
  localparam int          DEPTH  = 8;
  localparam int          H      = 20;   // system cycles per PS/2 clock phase

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        ps2_clk   = 1'b1;
  logic        ps2_data  = 1'b1;
  logic [31:0] mem_addr  = '0;
  logic        rd_strobe = 1'b0;
  logic        wren      = 1'b0;
  wire         hit;
  wire  [31:0] rd_data;

  always #5 clock = ~clock;

  ps2_rx_mmio dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .mem_addr  (mem_addr),
    .rd_strobe (rd_strobe),
    .wren      (wren),
    .hit       (hit),
    .rd_data   (rd_data)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: buffered codes and sticky flags
  logic [7:0] q[$];
  bit m_perr = 0;
  bit m_ovf  = 0;
  bit m_ferr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    if (q.size() == 0) return 32'h0;
    return 32'h100 | 32'(q[0]);
  endfunction

  function automatic logic [31:0] exp_stat();
    logic [31:0] w;
    w = 32'(q.size());
    if (q.size() == 0)     w = w + 32'd32;
    if (q.size() == DEPTH) w = w + 32'd64;
    if (m_perr)            w = w + 32'd256;
    if (m_ovf)             w = w + 32'd512;
    if (m_ferr)            w = w + 32'd1024;
    return w;
  endfunction

  function automatic bit odd_par(input logic [7:0] code);
    return ($countones(code) % 2) == 0;
  endfunction

  function automatic void model_frame(input logic [7:0] code, input bit par, input bit stop);
    if (stop && (($countones(code) + int'(par)) % 2 == 1)) begin
      if (q.size() < DEPTH) q.push_back(code);
      else                  m_ovf = 1;
    end else begin
      m_perr = 1;
    end
  endfunction

  task automatic send_bit(input bit b);
    @(posedge clock); #1 ps2_data = b;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par, input bit stop);
    logic [10:0] f;
    f = {stop, par, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    repeat (H) @(posedge clock);
    model_frame(code, par, stop);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr);
    logic [31:0] exp;
    exp = (addr == A_DATA) ? exp_data() : exp_stat();
    @(posedge clock); #1 mem_addr = addr; rd_strobe = 1'b1;
    @(negedge clock);
    check(tag, rd_data, exp);
    @(posedge clock); #1 rd_strobe = 1'b0; mem_addr = '0;
    if (addr == A_DATA && q.size() != 0) void'(q.pop_front());
  endtask

  task automatic wr(input logic [31:0] addr);
    @(posedge clock); #1 mem_addr = addr; wren = 1'b1;
    @(posedge clock); #1 wren = 1'b0; mem_addr = '0;
    if (addr == A_STAT) begin m_perr = 0; m_ovf = 0; m_ferr = 0; end
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  code;
    logic [31:0] addr;
    int          kind;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hit", {31'b0, hit}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    mem_addr = A_STAT;
    @(negedge clock);
    check("reset_stat_in_reset", rd_data, 32'h20);
    mem_addr = '0;
    @(posedge clock); #1 reset_n = 1'b1;
    rd("reset_stat", A_STAT);

    // Single good frame 0x1C
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    rd("f1c_stat_before", A_STAT);
    rd("f1c_data", A_DATA);
    rd("f1c_data_empty", A_DATA);
    rd("f1c_stat_after", A_STAT);

    // Bad parity 0xF0, then clear
    send_frame(8'hF0, 1'b0, 1'b1);
    rd("perr_stat", A_STAT);
    wr(A_DATA);
    rd("perr_after_data_store", A_STAT);
    wr(A_STAT);
    rd("perr_cleared", A_STAT);

    // Overflow: nine frames, no reads
    for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
    rd("ovf_stat", A_STAT);
    for (int i = 1; i <= 8; i++) rd($sformatf("ovf_data_%0d", i), A_DATA);
    rd("ovf_data_empty", A_DATA);
    wr(A_STAT);

    // Pop in the same cycle as a push
    send_frame(8'h15, odd_par(8'h15), 1'b1);
    f = {1'b1, odd_par(8'h2A), 8'h2A, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(posedge clock); #1 ps2_data = 1'b1;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clock);
    #1 mem_addr = A_DATA; rd_strobe = 1'b1;
    @(negedge clock);
    check("overlap_head", rd_data, 32'h115);
    @(posedge clock); #1 rd_strobe = 1'b0; mem_addr = '0;
    void'(q.pop_front());
    model_frame(8'h2A, odd_par(8'h2A), 1'b1);
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b1;
    repeat (H) @(posedge clock);
    rd("overlap_stat", A_STAT);
    rd("overlap_next", A_DATA);

    // Reset in the middle of a frame, with a stale entry and flag present
    send_frame(8'h33, odd_par(8'h33), 1'b1);
    send_frame(8'h44, ~odd_par(8'h44), 1'b1);
    f = {1'b1, 1'b0, 8'hA5, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    @(posedge clock); #1 reset_n = 1'b0; ps2_data = 1'b1;
    q.delete(); m_perr = 0; m_ovf = 0; m_ferr = 0;
    mem_addr = A_DATA;
    @(negedge clock);
    check("midreset_data", rd_data, 32'h0);
    mem_addr = A_STAT;
    @(negedge clock);
    check("midreset_stat", rd_data, 32'h20);
    mem_addr = '0;
    @(posedge clock); #1 reset_n = 1'b1;
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    rd("midreset_5a", A_DATA);
    rd("midreset_stat_after", A_STAT);

    // Address decode
    for (int i = 0; i < 4; i++) begin
      addr = 32'h0001_0000 | 32'($urandom_range(0, 4095));
      @(posedge clock); #1 mem_addr = addr;
      @(negedge clock);
      check($sformatf("miss_hit_%0d", i), {31'b0, hit}, 32'h0);
      check($sformatf("miss_data_%0d", i), rd_data, 32'h0);
    end
    @(posedge clock); #1 mem_addr = A_DATA;
    @(negedge clock);
    check("hit_data", {31'b0, hit}, 32'h1);
    #1 mem_addr = '0;

    // Randomized frames with interleaved reads
    for (int n = 0; n < 16; n++) begin
      code = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      if (kind == 0)      send_frame(code, ~odd_par(code), 1'b1);
      else if (kind == 1) send_frame(code, odd_par(code), 1'b0);
      else                send_frame(code, odd_par(code), 1'b1);
      if ($urandom_range(0, 2) == 0) rd($sformatf("rand_data_%0d", n), A_DATA);
      if ($urandom_range(0, 1) == 0) rd($sformatf("rand_stat_%0d", n), A_STAT);
      if ($urandom_range(0, 5) == 0) wr(A_STAT);
    end
    rd("rand_stat_final", A_STAT);
    while (q.size() != 0) rd("rand_drain", A_DATA);
    rd("rand_empty", A_DATA);

`ifdef PS2_RX_TIMEOUT_EN
    // Stalled frame: start + 4 data bits, then idle pads
    wr(A_STAT);
    f = {1'b1, 1'b0, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    @(posedge clock); #1 ps2_data = 1'b1;
    repeat (49000) @(posedge clock);
    rd("wd_before", A_STAT);
    repeat (1100) @(posedge clock);
    m_ferr = 1;
    rd("wd_after", A_STAT);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    rd("wd_recover", A_DATA);
    wr(A_STAT);
    rd("wd_cleared", A_STAT);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
